stack_exec_unit: RTL

STACK_EXEC_UNIT -- requirements
Module: stack_exec_unit

---
 rtl/stack_exec_unit.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/stack_exec_unit.sv
`default_nettype none
// ============================================================================
//  Module   : stack_exec_unit
//  Brief    : Executes decoded WASM stack instructions against an external
//             operand stack: validates depth, computes the result
//             (iterative multiply) and issues one push/pop strobe per op.
//  Revision : 1.0 - initial release
// ============================================================================
module stack_exec_unit #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  parameter int DW    = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [7:0]         in_opcode,
  input  logic [WIDTH-1:0]   in_imm,
  input  logic [3*WIDTH-1:0] pop_window,
  output logic               push_num,
  output logic [1:0]         pop_num,
  output logic [WIDTH-1:0]   push_data,
  output logic [DW-1:0]      depth,
  output logic               trap,
  output logic [1:0]         trap_code
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_EXEC = 2'd2,
    S_TRAP = 2'd3
  } state_t;

  // Opcode table lookup: {legal, push, pops[1:0]}
  function automatic logic [3:0] decode(input logic [7:0] op);
    case (op)
      8'h41:                         decode = 4'b1100;
      8'h1A:                         decode = 4'b1001;
      8'h1B:                         decode = 4'b1111;
      8'h45:                         decode = 4'b1101;
      8'h46, 8'h6A, 8'h6B, 8'h6C,
      8'h71, 8'h72, 8'h73:           decode = 4'b1110;
      default:                       decode = 4'b0000;
    endcase
  endfunction

  state_t           state_q, state_d;
  logic [7:0]       opcode_q;
  logic [WIDTH-1:0] imm_q, top_q, second_q, third_q;
  logic [WIDTH-1:0] acc_q, mcand_q, mplier_q;
  logic [CW-1:0]    cnt_q;
  logic [DW-1:0]    depth_q;
  logic             trap_q;
  logic [1:0]       trap_code_q;

  logic [3:0]       w_dec, w_exec_dec;
  logic             w_hs;
  logic [DW:0]      w_depth_ext, w_pops_ext, w_push_ext;
  logic [1:0]       w_fail_code;
  logic [WIDTH-1:0] w_result;

  assign w_dec       = decode(in_opcode);
  assign w_exec_dec  = decode(opcode_q);
  assign w_hs        = in_valid && (state_q == S_IDLE);
  assign w_depth_ext = {1'b0, depth_q};
  assign w_pops_ext  = (DW+1)'(w_dec[1:0]);
  assign w_push_ext  = (DW+1)'(w_dec[2]);

  // Admission checks in priority order; depth math widened so depth+1 cannot wrap
  always_comb begin
    w_fail_code = 2'd0;
    if (!w_dec[3]) begin
      w_fail_code = 2'd3;
    end else if (w_depth_ext < w_pops_ext) begin
      w_fail_code = 2'd1;
    end else if ((w_depth_ext - w_pops_ext + w_push_ext) > (DW+1)'(DEPTH - 1)) begin
      w_fail_code = 2'd2;
    end
  end

  // Next-state selection
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (w_hs) begin
          if (w_fail_code != 2'd0)    state_d = S_TRAP;
          else if (in_opcode == 8'h6C) state_d = S_MUL;
          else                         state_d = S_EXEC;
        end
      end
      S_MUL:   if (cnt_q == CW'(WIDTH - 1)) state_d = S_EXEC;
      S_EXEC:  state_d = S_IDLE;
      default: state_d = S_TRAP;
    endcase
  end

  // State register; reset aborts any in-flight instruction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Operand capture, shift-add multiplier, depth tracking and sticky trap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opcode_q    <= 8'd0;
      imm_q       <= '0;
      top_q       <= '0;
      second_q    <= '0;
      third_q     <= '0;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      cnt_q       <= '0;
      depth_q     <= '0;
      trap_q      <= 1'b0;
      trap_code_q <= 2'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (w_hs) begin
            opcode_q <= in_opcode;
            imm_q    <= in_imm;
            top_q    <= pop_window[WIDTH-1:0];
            second_q <= pop_window[2*WIDTH-1:WIDTH];
            third_q  <= pop_window[3*WIDTH-1:2*WIDTH];
            acc_q    <= '0;
            mcand_q  <= pop_window[2*WIDTH-1:WIDTH];
            mplier_q <= pop_window[WIDTH-1:0];
            cnt_q    <= '0;
            if (w_fail_code != 2'd0) begin
              trap_q      <= 1'b1;
              trap_code_q <= w_fail_code;
            end
          end
        end
        S_MUL: begin
          acc_q    <= acc_q + (mplier_q[0] ? mcand_q : '0);
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + CW'(1);
        end
        S_EXEC: begin
          depth_q <= depth_q - DW'(w_exec_dec[1:0]) + DW'(w_exec_dec[2]);
        end
        default: ;
      endcase
    end
  end

  // Result of the latched instruction, consumed only during EXEC
  always_comb begin
    w_result = '0;
    case (opcode_q)
      8'h41:   w_result = imm_q;
      8'h1B:   w_result = (top_q != '0) ? third_q : second_q;
      8'h45:   w_result = {{(WIDTH-1){1'b0}}, (top_q == '0)};
      8'h46:   w_result = {{(WIDTH-1){1'b0}}, (second_q == top_q)};
      8'h6A:   w_result = second_q + top_q;
      8'h6B:   w_result = second_q - top_q;
      8'h6C:   w_result = acc_q;
      8'h71:   w_result = second_q & top_q;
      8'h72:   w_result = second_q | top_q;
      8'h73:   w_result = second_q ^ top_q;
      default: w_result = '0;
    endcase
  end

  // Stack strobes exist only in EXEC; data is forced to zero without a push
  always_comb begin
    in_ready  = (state_q == S_IDLE);
    push_num  = (state_q == S_EXEC) && w_exec_dec[2];
    pop_num   = (state_q == S_EXEC) ? w_exec_dec[1:0] : 2'd0;
    push_data = push_num ? w_result : '0;
    depth     = depth_q;
    trap      = trap_q;
    trap_code = trap_code_q;
  end

endmodule
`default_nettype wire
